mem_arbiter: RTL and testbench

Shares the PUNEH processor's single-port memory between two requesters: the CPU port, driven from the controller's readMEM/writeMEM/address path, and an external port for a program loader or debug/DMA agent. A four-state FSM grants one requester at a time, launches exactly one memory access, and waits a parameterised read latency. It then returns an ack pulse with captured read data to the winning requester. The block sits between the processor datapath's address/data muxes and the memory.

---
 rtl/puneh_arb_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 35 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puneh_arb_pkg.sv
// Shared types for the PUNEH memory arbiter: FSM states, requester
// identities and the read-latency counter width.
package puneh_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    CPU,
    EXT
  } owner_t;

  // Holds MEM_LAT-1, so MEM_LAT may range 1..7.
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational requester selection for mem_arbiter.
// PUNEH_ARB_RR_EN defined  : a tie goes to the requester that is not last_owner.
// PUNEH_ARB_RR_EN undefined: fixed priority, the CPU wins every tie.
module mem_arb_pick
  import puneh_arb_pkg::*;
(
  input  logic   cpu_req,
  input  logic   ext_req,
  input  owner_t last_owner,
  output owner_t winner,
  output logic   valid
);

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    valid  = cpu_req | ext_req;
    winner = CPU;
    if (cpu_req && ext_req) begin
`ifdef PUNEH_ARB_RR_EN
      winner = (last_owner == CPU) ? EXT : CPU;
`else
      winner = CPU;
`endif
    end else if (ext_req) begin
      winner = EXT;
    end
  end

`ifndef PUNEH_ARB_RR_EN
  // Fixed priority never looks at the previous owner.
  logic unused_last_owner;
  assign unused_last_owner = (last_owner == EXT);
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the PUNEH single-port memory.
// One transaction at a time: IDLE (arbitrate and capture) -> ACCESS (one
// strobe) -> [WAIT for read latency] -> RESP (ack to owner) -> IDLE.
// Tie-break policy is selected by the PUNEH_ARB_RR_EN macro (see mem_arb_pick).
module mem_arbiter
  import puneh_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ext_req,
  input  logic              ext_wr,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_owner_q, last_owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  owner_t pick_winner;
  logic   pick_valid;

  mem_arb_pick u_pick (
    .cpu_req   (cpu_req),
    .ext_req   (ext_req),
    .last_owner(last_owner_q),
    .winner    (pick_winner),
    .valid     (pick_valid)
  );

  // Next state, request capture, latency countdown and read-data capture.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_winner;
          if (pick_winner == CPU) begin
            wr_d    = cpu_wr;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end else begin
            wr_d    = ext_wr;
            addr_d  = ext_addr;
            wdata_d = ext_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (wr_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        last_owner_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= CPU;
      last_owner_q <= EXT;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
    end
  end

  // Address and write data come straight from the capture registers so they
  // hold steady outside ACCESS; strobes and acks decode the state alone.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_write = (state_q == ACCESS) &&  wr_q;
  assign mem_read  = (state_q == ACCESS) && !wr_q;
  assign cpu_ack   = (state_q == RESP) && (owner_q == CPU);
  assign ext_ack   = (state_q == RESP) && (owner_q == EXT);
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked
// every cycle, directed scenarios with literal expectations, and two extra
// instances sweeping the read latency to its limits.
module tb_mem_arbiter;
  import puneh_arb_pkg::*;

  localparam int LAT = 3;

  int checks   = 0;
  int failures = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_wr, ext_req, ext_wr;
  logic [15:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_ack, ext_ack, mem_read, mem_write, busy;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .ext_req(ext_req), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ack(ext_ack),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Unwritten locations read back a fixed address-derived pattern.
  function automatic logic [15:0] dflt(input logic [15:0] a);
    return (a == 16'h0020) ? 16'h1234 : (a ^ 16'h5A00);
  endfunction

  // ---------------- memory environment for the main instance ----------------
  logic [15:0] env_mem [256];
  bit          env_wr  [256];
  logic [15:0] pipe    [8];

  always @(posedge clk) begin
    pipe[0] <= mem_read ? (env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : dflt(mem_addr)) : 16'hDEAD;
    for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    if (mem_write) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
      env_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign mem_rdata = pipe[LAT-1];

  // ---------------- transaction-level reference model ----------------
  // A transaction is described by its start cycle offset k (1 = access
  // cycle) and duration: writes ack at k=2, reads at k=2+LAT.
  bit          m_active;
  int          m_k, m_dur;
  owner_t      m_owner, m_last, m_win;
  logic        m_wr, s_wr_in;
  logic [15:0] m_addr, m_wdata, m_rdata, s_addr_in, s_wdata_in;
  logic [15:0] model_mem [256];
  bit          model_wr  [256];

  function automatic owner_t model_pick(input logic c, input logic e, input owner_t last);
    if (c && e) begin
`ifdef PUNEH_ARB_RR_EN
      return (last == CPU) ? EXT : CPU;
`else
      return CPU;
`endif
    end
    return c ? CPU : EXT;
  endfunction

  assign m_win      = model_pick(cpu_req, ext_req, m_last);
  assign s_wr_in    = (m_win == CPU) ? cpu_wr    : ext_wr;
  assign s_addr_in  = (m_win == CPU) ? cpu_addr  : ext_addr;
  assign s_wdata_in = (m_win == CPU) ? cpu_wdata : ext_wdata;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0; m_k <= 0; m_dur <= 0; m_last <= EXT; m_owner <= CPU;
      m_wr <= 1'b0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (!m_active) begin
      if (cpu_req || ext_req) begin
        m_active <= 1'b1; m_k <= 1; m_owner <= m_win;
        m_wr <= s_wr_in; m_addr <= s_addr_in; m_wdata <= s_wdata_in;
        m_dur <= s_wr_in ? 2 : 2 + LAT;
      end
    end else begin
      if (m_k == 1 && m_wr) begin
        model_mem[m_addr[7:0]] <= m_wdata;
        model_wr[m_addr[7:0]]  <= 1'b1;
      end
      if (m_k == m_dur) begin
        m_active <= 1'b0;
        m_last   <= m_owner;
      end else begin
        m_k <= m_k + 1;
        if (!m_wr && m_k + 1 == m_dur)
          m_rdata <= model_wr[m_addr[7:0]] ? model_mem[m_addr[7:0]] : dflt(m_addr);
      end
    end
  end

  // ---------------- latency sweep instances (MEM_LAT 1 and 7) ----------------
  logic [1:0]  s_req, s_ack, s_eack, s_rd, s_wrs, s_busy;
  logic [15:0] s_addr;
  logic [15:0] s_rdata [2];
  logic [15:0] s_maddr [2];
  logic [15:0] s_mwd   [2];
  logic [15:0] s_min   [2];
  int          s_rdcnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int L = (g == 0) ? 1 : 7;
    logic [15:0] spipe [8];
    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_req(s_req[g]), .cpu_wr(1'b0), .cpu_addr(s_addr), .cpu_wdata(16'h0000), .cpu_ack(s_ack[g]),
      .ext_req(1'b0), .ext_wr(1'b0), .ext_addr(16'h0000), .ext_wdata(16'h0000), .ext_ack(s_eack[g]),
      .rdata(s_rdata[g]), .mem_addr(s_maddr[g]), .mem_wdata(s_mwd[g]),
      .mem_read(s_rd[g]), .mem_write(s_wrs[g]), .mem_rdata(s_min[g]), .busy(s_busy[g])
    );
    always @(posedge clk) begin
      spipe[0] <= s_rd[g] ? dflt(s_maddr[g]) : 16'hDEAD;
      for (int i = 1; i < 8; i++) spipe[i] <= spipe[i-1];
    end
    assign s_min[g] = spipe[L-1];
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",      busy,      m_active);
      chk("cpu_ack",   cpu_ack,   m_active && m_k == m_dur && m_owner == CPU);
      chk("ext_ack",   ext_ack,   m_active && m_k == m_dur && m_owner == EXT);
      chk("mem_write", mem_write, m_active && m_k == 1 && m_wr);
      chk("mem_read",  mem_read,  m_active && m_k == 1 && !m_wr);
      chk("mem_addr",  mem_addr,  m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("rdata",     rdata,     m_rdata);
      chk("strobe_excl", mem_read & mem_write, 0);
      for (int g = 0; g < 2; g++) begin
        chk("sweep_excl", s_rd[g] & s_wrs[g], 0);
        if (s_rd[g]) s_rdcnt[g]++;
      end
    end
  end

  // One transaction from a fresh IDLE cycle; k counts cycles after sampling.
  task automatic run_txn(input bit ext, input bit wr, input logic [15:0] a, input logic [15:0] d,
                         output int wk, output int rk, output int ak, output int other,
                         output logic [15:0] rd);
    wk = -1; rk = -1; ak = -1; other = 0; rd = '0;
    @(negedge clk);
    if (ext) begin ext_req = 1; ext_wr = wr; ext_addr = a; ext_wdata = d; end
    else     begin cpu_req = 1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; end
    for (int k = 1; k <= 25 && ak < 0; k++) begin
      @(negedge clk);
      if (mem_write && wk < 0) wk = k;
      if (mem_read  && rk < 0) rk = k;
      if (ext ? cpu_ack : ext_ack) other++;
      if (ext ? ext_ack : cpu_ack) begin ak = k; rd = rdata; end
    end
    cpu_req = 0; ext_req = 0;
  endtask

  int          wk, rk, ak, other, nack, a0, a1;
  logic [15:0] rd, r0, r1;
  owner_t      order [4];
  owner_t      exp_order [4];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_wr = 0; ext_addr = 0; ext_wdata = 0; s_req = 0; s_addr = 0;
    s_rdcnt[0] = 0; s_rdcnt[1] = 0;
    @(posedge clk); cmp_en = 1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {cpu_ack, ext_ack}, 0);
    chk("rst_strobes", {mem_read, mem_write}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #2 rst = 1;

    // CPU write alone
    run_txn(0, 1, 16'h0010, 16'hBEEF, wk, rk, ak, other, rd);
    chk("w_strobe_cycle", wk, 1);
    chk("w_ack_cycle", ak, 2);
    chk("w_no_ext_ack", other, 0);
    chk("w_no_read", rk, -1);
    @(negedge clk);
    chk("w_addr_hold", mem_addr, 16'h0010);
    chk("w_wdata_hold", mem_wdata, 16'hBEEF);
    chk("w_rdata_untouched", rdata, 0);

    // External read, MEM_LAT=3
    run_txn(1, 0, 16'h0020, 16'h0000, wk, rk, ak, other, rd);
    chk("r_strobe_cycle", rk, 1);
    chk("r_ack_cycle", ak, 5);
    chk("r_rdata", rd, 16'h1234);
    chk("r_no_cpu_ack", other, 0);

    // Both requests held: each acked requester re-requests in the next IDLE
`ifdef PUNEH_ARB_RR_EN
    exp_order = '{CPU, EXT, CPU, EXT};
`else
    exp_order = '{CPU, CPU, CPU, CPU};
`endif
    @(negedge clk);
    cpu_req = 1; cpu_wr = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h1111;
    ext_req = 1; ext_wr = 1; ext_addr = 16'h0041; ext_wdata = 16'h2222;
    nack = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      @(negedge clk);
      cpu_req = 1; ext_req = 1;
      if (cpu_ack) begin order[nack] = CPU; nack++; cpu_req = 0; end
      if (ext_ack) begin order[nack] = EXT; nack++; ext_req = 0; end
    end
    cpu_req = 0; ext_req = 0;
    chk("tie_ack_count", nack, 4);
    for (int i = 0; i < 4; i++) chk("tie_order", order[i], exp_order[i]);
    repeat (3) @(negedge clk);

    // CPU drops req (and changes address/op) after sampling
    @(negedge clk);
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0030;
    nack = 0; ak = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin cpu_addr = 16'hFFFF; cpu_wr = 1; end
      if (k == 2) cpu_req = 0;
      if (cpu_ack) begin nack++; if (ak < 0) begin ak = k; rd = rdata; end end
    end
    cpu_wr = 0;
    chk("drop_ack_cycle", ak, 5);
    chk("drop_ack_once", nack, 1);
    chk("drop_rdata", rd, 16'h5A30);

    // Reset during WAIT, then a fresh read
    @(negedge clk);
    cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h0050;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk); #2 rst = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rdata", rdata, 0);
    chk("rst_mid_ack", cpu_ack, 0);
    cpu_req = 0;
    @(posedge clk); #2 rst = 1;
    nack = 0;
    repeat (3) begin @(negedge clk); if (cpu_ack || ext_ack) nack++; end
    chk("rst_no_ack", nack, 0);
    run_txn(0, 0, 16'h0020, 16'h0000, wk, rk, ak, other, rd);
    chk("post_rst_ack_cycle", ak, 5);
    chk("post_rst_rdata", rd, 16'h1234);

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=7 instances
    @(negedge clk);
    s_addr = 16'h0060; s_req = 2'b11;
    a0 = -1; a1 = -1; r0 = '0; r1 = '0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (s_ack[0] && a0 < 0) begin a0 = k; r0 = s_rdata[0]; s_req[0] = 0; end
      if (s_ack[1] && a1 < 0) begin a1 = k; r1 = s_rdata[1]; s_req[1] = 0; end
    end
    s_req = 0;
    chk("lat1_ack_cycle", a0, 3);
    chk("lat7_ack_cycle", a1, 9);
    chk("lat1_rdata", r0, 16'h5A60);
    chk("lat7_rdata", r1, 16'h5A60);
    chk("lat1_one_read", s_rdcnt[0], 1);
    chk("lat7_one_read", s_rdcnt[1], 1);
    chk("sweep_no_ext_ack", s_eack, 0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
